control_unit: RTL and testbench

- Multi-cycle sequencer for the CPU datapath.
- Decodes opcode/funct from instruction memory output and drives every datapath select and write strobe.
- Gates PC advance through halt, and stalls the IN instruction until an operator presses the enter button.
- Sits beside the datapath inside the CPU top; all datapath control inputs are sourced here.

---
 rtl/ctrl_pkg.sv | 170 +++++++++++++++++
 rtl/input_sync_edge.sv | 29 ++
 rtl/control_unit.sv | 102 ++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the CPU control unit: opcodes, functs, ALU ops,
// datapath select codes, sequencer states and the per-instruction decode.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_MEM     = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_WB      = 3'd4,
        ST_HALTED  = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_IN    = 6'h30;
    localparam logic [5:0] OP_OUT   = 6'h31;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_SLT   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_NOR   = 4'd7,
        ALU_XOR   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        M16_IMM  = 2'd0,
        M16_SW   = 2'd1,
        M16_PC   = 2'd2,
        M16_RSVD = 2'd3
    } mux16_e;

    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_BEQ  = 3'd1,
        PC_BNE  = 3'd2,
        PC_JUMP = 3'd3,
        PC_JREG = 3'd4
    } mux_pc_e;

    // Which state follows EXEC for a given opcode.
    typedef enum logic [1:0] {
        FLOW_WB      = 2'd0,
        FLOW_MEM     = 2'd1,
        FLOW_WAIT_IN = 2'd2,
        FLOW_HALT    = 2'd3
    } flow_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    disp_we;
        logic    mux5;
        mux16_e  mux16;
        logic    mux32;
        mux_pc_e mux_pc;
        alu_op_e alu;
        logic    mem_to_reg;
    } ctrl_t;

    // An all-zero control word is a NOP: no strobes, PC+1.
    localparam ctrl_t CTRL_NOP = '0;

    function automatic flow_e op_flow(input logic [5:0] opcode);
        flow_e f;
        case (opcode)
            OP_LW:   f = FLOW_MEM;
            OP_IN:   f = FLOW_WAIT_IN;
            OP_HLT:  f = FLOW_HALT;
            default: f = FLOW_WB;
        endcase
        return f;
    endfunction

    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_we = 1'b1;
                case (funct)
                    FN_ADD:  c.alu = ALU_ADD;
                    FN_SUB:  c.alu = ALU_SUB;
                    FN_AND:  c.alu = ALU_AND;
                    FN_OR:   c.alu = ALU_OR;
                    FN_SLT:  c.alu = ALU_SLT;
                    FN_SLL:  c.alu = ALU_SLL;
                    FN_SRL:  c.alu = ALU_SRL;
                    FN_NOR:  c.alu = ALU_NOR;
                    FN_XOR:  c.alu = ALU_XOR;
                    FN_JR: begin
                        c.reg_we = 1'b0;
                        c.mux_pc = PC_JREG;
                    end
                    default: c.reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                c.reg_we = 1'b1;
                c.mux5   = 1'b1;
                c.mux32  = 1'b1;
                c.mux16  = M16_IMM;
                case (opcode)
                    OP_ANDI: c.alu = ALU_AND;
                    OP_ORI:  c.alu = ALU_OR;
                    OP_SLTI: c.alu = ALU_SLT;
                    default: c.alu = ALU_ADD;
                endcase
            end
            OP_LW: begin
                c.alu        = ALU_ADD;
                c.mux32      = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mux5       = 1'b1;
                c.reg_we     = 1'b1;
            end
            OP_SW: begin
                c.alu    = ALU_ADD;
                c.mux32  = 1'b1;
                c.mem_we = 1'b1;
            end
            OP_BEQ: begin
                c.alu    = ALU_SUB;
                c.mux_pc = PC_BEQ;
            end
            OP_BNE: begin
                c.alu    = ALU_SUB;
                c.mux_pc = PC_BNE;
            end
            OP_J:   c.mux_pc = PC_JUMP;
            OP_IN: begin
                c.mux16  = M16_SW;
                c.mux32  = 1'b1;
                c.alu    = ALU_PASSB;
                c.mux5   = 1'b1;
                c.reg_we = 1'b1;
            end
            OP_OUT: c.disp_we = 1'b1;
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pushbutton followed by a
// one-cycle rising-edge pulse generator.
module input_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: flops use non-blocking assignment so every stage samples the
    // previous stage's old value; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: decodes the fetched instruction and drives every
// datapath select and write strobe, holding the PC except in write-back.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       enter,
    output logic       halt,
    output logic       sreg,
    output logic       smux5,
    output logic [1:0] smux16,
    output logic       smux32,
    output logic [2:0] smuxPC,
    output logic [3:0] salu,
    output logic       smem,
    output logic       sdisplay,
    output logic       smemtoreg,
    output logic [2:0] state
);

    state_e state_q, state_d;
    ctrl_t  op_q, op_d;
    ctrl_t  dec;
    ctrl_t  sel;
    logic   enter_pulse;
    logic   in_wb;

    input_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_enter_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(enter),
        .pulse   (enter_pulse)
    );

    assign dec = decode(opcode, funct);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= CTRL_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                op_d = dec;
                case (op_flow(opcode))
                    FLOW_MEM:     state_d = ST_MEM;
                    FLOW_WAIT_IN: state_d = ST_WAIT_IN;
                    FLOW_HALT:    state_d = ST_HALTED;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM:     state_d = ST_WB;
            ST_WAIT_IN: if (enter_pulse) state_d = ST_WB;
            ST_WB:      state_d = ST_FETCH;
            ST_HALTED:  state_d = ST_HALTED;
            default:    state_d = ST_FETCH;
        endcase
    end

    // EXEC sees the freshly fetched instruction directly; later states replay
    // the copy captured at the end of EXEC, so selects never glitch mid-op.
    always_comb begin
        sel = CTRL_NOP;
        case (state_q)
            ST_EXEC:                    sel = dec;
            ST_MEM, ST_WAIT_IN, ST_WB:  sel = op_q;
            default:                    sel = CTRL_NOP;
        endcase
    end

    assign in_wb     = (state_q == ST_WB);
    assign halt      = ~in_wb;
    assign sreg      = in_wb & sel.reg_we;
    assign smem      = in_wb & sel.mem_we;
    assign sdisplay  = in_wb & sel.disp_we;
    assign smuxPC    = in_wb ? sel.mux_pc : PC_INC;
    assign smux5     = sel.mux5;
    assign smux16    = sel.mux16;
    assign smux32    = sel.mux32;
    assign salu      = sel.alu;
    assign smemtoreg = sel.mem_to_reg;
    assign state     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks the instruction classes through the
// sequencer and compares every observed control against hand-computed values.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h3E;
    logic [5:0] funct = 6'h00;
    logic       enter = 1'b0;
    logic       halt, sreg, smux5, smux32, smem, sdisplay, smemtoreg;
    logic [1:0] smux16;
    logic [2:0] smuxPC, state;
    logic [3:0] salu;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_unit #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .enter    (enter),
        .halt     (halt),
        .sreg     (sreg),
        .smux5    (smux5),
        .smux16   (smux16),
        .smux32   (smux32),
        .smuxPC   (smuxPC),
        .salu     (salu),
        .smem     (smem),
        .sdisplay (sdisplay),
        .smemtoreg(smemtoreg),
        .state    (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Three-cycle op: FETCH -> EXEC -> WB, checking strobes and PC select.
    task automatic run_simple(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic rw, input logic mw, input logic dw,
                              input logic [2:0] pc, input bit alu_care, input logic [3:0] alu);
        opcode = op;
        funct  = fn;
        check({name, "/fetch_state"}, 32'(state), 0);
        cyc();
        check({name, "/exec_state"}, 32'(state), 1);
        check({name, "/exec_strobes"}, {29'd0, sreg, smem, sdisplay}, 0);
        check({name, "/exec_pc"}, 32'(smuxPC), 0);
        if (alu_care) check({name, "/exec_alu"}, 32'(salu), 32'(alu));
        cyc();
        check({name, "/wb_state"}, 32'(state), 4);
        check({name, "/wb_halt"}, 32'(halt), 0);
        check({name, "/wb_strobes"}, {29'd0, sreg, smem, sdisplay}, {29'd0, rw, mw, dw});
        check({name, "/wb_pc"}, 32'(smuxPC), 32'(pc));
        if (alu_care) check({name, "/wb_alu"}, 32'(salu), 32'(alu));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (2) @(posedge clk);
        #1;
        check("rst/state", 32'(state), 0);
        check("rst/halt", 32'(halt), 1);
        check("rst/strobes", {29'd0, sreg, smem, sdisplay}, 0);
        check("rst/selects", {20'd0, smux5, smux16, smux32, smuxPC, salu, smemtoreg}, 0);
        reset = 1'b0;

        // ADDI
        opcode = 6'h08;
        check("addi/fetch_halt", 32'(halt), 1);
        check("addi/fetch_sreg", 32'(sreg), 0);
        cyc();
        check("addi/exec_state", 32'(state), 1);
        check("addi/exec_halt", 32'(halt), 1);
        check("addi/exec_sreg", 32'(sreg), 0);
        cyc();
        check("addi/wb_state", 32'(state), 4);
        check("addi/wb_halt", 32'(halt), 0);
        check("addi/wb_sreg", 32'(sreg), 1);
        check("addi/wb_sel", {27'd0, smux5, smux32, smux16, smemtoreg}, {27'd0, 1'b1, 1'b1, 2'd0, 1'b0});
        check("addi/wb_alu", 32'(salu), 0);
        cyc();
        check("addi/next_state", 32'(state), 0);
        check("addi/next_halt", 32'(halt), 1);

        // LW; enter rises here so its edge falls outside WAIT_IN and is dropped
        opcode = 6'h23;
        enter  = 1'b1;
        cyc();
        check("lw/exec_state", 32'(state), 1);
        check("lw/exec_m2r", 32'(smemtoreg), 1);
        check("lw/exec_sreg", 32'(sreg), 0);
        cyc();
        check("lw/mem_state", 32'(state), 2);
        check("lw/mem_m2r", 32'(smemtoreg), 1);
        check("lw/mem_sreg", 32'(sreg), 0);
        check("lw/mem_halt", 32'(halt), 1);
        cyc();
        check("lw/wb_state", 32'(state), 4);
        check("lw/wb_sreg", 32'(sreg), 1);
        check("lw/wb_m2r", 32'(smemtoreg), 1);
        check("lw/wb_sel", {29'd0, smux5, smux32, smem}, {29'd0, 1'b1, 1'b1, 1'b0});
        cyc();
        check("lw/next_state", 32'(state), 0);

        // IN with enter already high on entry
        opcode = 6'h30;
        cyc();
        check("in/exec_state", 32'(state), 1);
        check("in/exec_alu", 32'(salu), 9);
        cyc();
        check("in/wait_state", 32'(state), 3);
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("in/wait_high", 32'(state), 3);
        end
        enter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("in/wait_low", {28'd0, sreg, state}, 3);
        end
        enter = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (state != 3'd4 && n < 6);
        check("in/wb_latency", 32'(n), 3);
        check("in/wb_state", 32'(state), 4);
        check("in/wb_sreg", 32'(sreg), 1);
        check("in/wb_m16", 32'(smux16), 1);
        check("in/wb_alu", 32'(salu), 9);
        check("in/wb_sel", {29'd0, smux5, smux32, halt}, {29'd0, 1'b1, 1'b1, 1'b0});
        enter = 1'b0;
        cyc();
        check("in/next_state", 32'(state), 0);

        //          name     op     fn     rw    mw    dw    pc    care alu
        run_simple("beq",   6'h04, 6'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'd1);
        run_simple("j",     6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0);
        run_simple("bne",   6'h05, 6'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 4'd1);
        run_simple("sub",   6'h00, 6'h22, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd1);
        run_simple("xor",   6'h00, 6'h26, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd8);
        run_simple("nor",   6'h00, 6'h27, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd7);
        run_simple("sll",   6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd5);
        run_simple("srl",   6'h00, 6'h02, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd6);
        run_simple("slt",   6'h00, 6'h2A, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd4);
        run_simple("jr",    6'h00, 6'h08, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 4'd0);
        run_simple("andi",  6'h0C, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2);
        run_simple("ori",   6'h0D, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd3);
        run_simple("slti",  6'h0A, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd4);
        run_simple("sw",    6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 4'd0);
        run_simple("out",   6'h31, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0);
        run_simple("unk3e", 6'h3E, 6'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
        run_simple("badfn", 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);

        // HLT
        opcode = 6'h3F;
        cyc();
        check("hlt/exec_state", 32'(state), 1);
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("hlt/halted", {27'd0, halt, sreg, state}, {27'd0, 1'b1, 1'b0, 3'd5});
        end
        reset = 1'b1;
        #1;
        check("hlt/reset_state", 32'(state), 0);
        check("hlt/reset_halt", 32'(halt), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("hlt/after_reset", 32'(state), 0);

        // SW aborted by reset in WB
        opcode = 6'h2B;
        cyc();
        check("swrst/exec_state", 32'(state), 1);
        cyc();
        check("swrst/wb_smem", 32'(smem), 1);
        #2;
        reset = 1'b1;
        #1;
        check("swrst/async_smem", 32'(smem), 0);
        check("swrst/async_state", 32'(state), 0);
        check("swrst/async_halt", 32'(halt), 1);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        opcode = 6'h3E;
        cyc();
        check("swrst/restart", {29'd0, state}, 1);
        check("swrst/restart_smem", 32'(smem), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
